// File: rtl/dsc_pkg.sv
// Shared definitions for the stochastic (stream-counting) multiplier.
//   dsc_state_e       : FSM states of dsc_mul_param
//   DSC_DEFAULT_WIDTH : default operand width
package dsc_pkg;

    localparam int unsigned DSC_DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } dsc_state_e;

endpackage

// File: rtl/dsc_mul_param_if.sv
// Request/result bundle of dsc_mul_param.
//   start : request a multiply (sampled only when idle)
//   a, b  : unsigned operands, captured on an accepted start
//   busy  : multiply in progress
//   done  : one-cycle completion pulse, z valid
//   z     : product, held until the next accepted start
//   ov    : full stream length traversed (qualifies done)
// Modports: master drives requests, slave is the multiplier.
interface dsc_mul_param_if #(
    parameter int unsigned WIDTH = dsc_pkg::DSC_DEFAULT_WIDTH
) ();

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   z;
    logic                 ov;

    modport master (
        output start, a, b,
        input  busy, done, z, ov
    );

    modport slave (
        input  start, a, b,
        output busy, done, z, ov
    );

endinterface

// File: rtl/dsc_sng.sv
// Stream-number generator: one free-running counter compared against a binary value.
//   clk, rst : clock, asynchronous active-low reset
//   inc      : advance the counter (wraps naturally at 2^WIDTH-1)
//   clr      : synchronous clear, has priority over inc
//   bin_in   : binary value the stream encodes
//   sn_out   : stream bit, counter < bin_in (unsigned)
//   wrap     : counter is at its maximum value
module dsc_sng #(
    parameter int unsigned WIDTH = dsc_pkg::DSC_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic [WIDTH-1:0] bin_in,
    output logic             sn_out,
    output logic             wrap
);

    logic [WIDTH-1:0] ctr_q, ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (clr) begin
            ctr_d = '0;
        end else if (inc) begin
            ctr_d = ctr_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign sn_out = (ctr_q < bin_in);
    assign wrap   = (ctr_q == '1);

endmodule

// File: rtl/dsc_mul_param.sv
// Unsigned multiplier that counts coincident ones of two unary streams.
// Stream A sweeps every cycle, stream B advances once per A sweep, so all
// 2^(2*WIDTH) counter pairs are visited and the count equals a*b.
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : dsc_mul_param_if slave (start, a, b -> busy, done, z, ov)
// Build option: define DSC_MUL_ZERO_SKIP_EN to finish a zero-operand request
// straight from IDLE to DONE (z=0, ov=0).
module dsc_mul_param
    import dsc_pkg::*;
#(
    parameter int unsigned WIDTH = DSC_DEFAULT_WIDTH
) (
    input logic              clk,
    input logic              rst,
    dsc_mul_param_if.slave   bus
);

    localparam int unsigned ZW = 2 * WIDTH;

    dsc_state_e        state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [ZW-1:0]     z_q;
    logic              load, run;
    logic              sn_a, sn_b, wrap_a, wrap_b;

    // Operand-zero detection only matters when the skip path is built in.
`ifdef DSC_MUL_ZERO_SKIP_EN
    logic skip_q;
    logic zero_op;
    assign zero_op = (bus.a == '0) || (bus.b == '0);
`endif

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        run     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    load = 1'b1;
`ifdef DSC_MUL_ZERO_SKIP_EN
                    state_d = zero_op ? StDone : StRun;
`else
                    state_d = StRun;
`endif
                end
            end
            StRun: begin
                run = 1'b1;
                // Last pair (max, max) is counted in this cycle.
                if (wrap_a && wrap_b) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                a_q <= bus.a;
                b_q <= bus.b;
                z_q <= '0;
            end else if (run) begin
                z_q <= z_q + ZW'(sn_a & sn_b);
            end
        end
    end

`ifdef DSC_MUL_ZERO_SKIP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skip_q <= 1'b0;
        end else if (load) begin
            skip_q <= zero_op;
        end
    end
`endif

    dsc_sng #(.WIDTH(WIDTH)) u_sng_a (
        .clk    (clk),
        .rst    (rst),
        .inc    (run),
        .clr    (load),
        .bin_in (a_q),
        .sn_out (sn_a),
        .wrap   (wrap_a)
    );

    // Stream B is the divided stream: it steps once per full A sweep.
    dsc_sng #(.WIDTH(WIDTH)) u_sng_b (
        .clk    (clk),
        .rst    (rst),
        .inc    (run && wrap_a),
        .clr    (load),
        .bin_in (b_q),
        .sn_out (sn_b),
        .wrap   (wrap_b)
    );

    assign bus.busy = (state_q != StIdle);
    assign bus.done = (state_q == StDone);
    assign bus.z    = z_q;
`ifdef DSC_MUL_ZERO_SKIP_EN
    assign bus.ov   = (state_q == StDone) && !skip_q;
`else
    assign bus.ov   = (state_q == StDone);
`endif

endmodule

// File: tb/tb_dsc_mul_param.sv
// Directed bench for dsc_mul_param: a WIDTH=3 instance driven from a vector
// table plus corner-case sequences, and a WIDTH=6 instance for the full-range case.
module tb_dsc_mul_param;

    localparam int LIMIT = 200;

`ifdef DSC_MUL_ZERO_SKIP_EN
    localparam int   ZCYC = 1;
    localparam logic ZOV  = 1'b0;
`else
    localparam int   ZCYC = 65;
    localparam logic ZOV  = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    dsc_mul_param_if #(.WIDTH(3)) bus3 ();
    dsc_mul_param_if #(.WIDTH(6)) bus6 ();

    dsc_mul_param #(.WIDTH(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    dsc_mul_param #(.WIDTH(6)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [5:0] z;
        logic       ov;
        int         cyc;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits for idle, issues a request at a negedge, then counts cycles until done.
    // cyc = index of the done cycle, counting the accepting cycle as 0.
    task automatic do_mul(input logic [2:0] av, input logic [2:0] bv,
                          input logic [2:0] nav, input logic [2:0] nbv, input logic keep,
                          output int wc, output int cyc, output int bcnt,
                          output logic [5:0] zv, output logic ovv, output int early);
        wc = 0;
        while (bus3.busy && wc < 10) begin
            @(negedge clk);
            wc++;
        end
        bus3.start = 1'b1;
        bus3.a     = av;
        bus3.b     = bv;
        cyc   = 0;
        bcnt  = 0;
        early = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus3.start = keep;
                bus3.a     = nav;
                bus3.b     = nbv;
            end
            if (bus3.busy) bcnt++;
            if (bus3.ov && !bus3.done) early++;
        end while (!bus3.done && cyc < LIMIT);
        zv  = bus3.z;
        ovv = bus3.ov;
    endtask

    initial begin
        int wc, cyc, bcnt, early, dcnt;
        logic [5:0] zv;
        logic ovv;

        vecs[0] = '{a: 3'd5, b: 3'd3, z: 6'd15, ov: 1'b1, cyc: 65};
        vecs[1] = '{a: 3'd7, b: 3'd7, z: 6'd49, ov: 1'b1, cyc: 65};
        vecs[2] = '{a: 3'd0, b: 3'd6, z: 6'd0,  ov: ZOV,  cyc: ZCYC};
        vecs[3] = '{a: 3'd1, b: 3'd1, z: 6'd1,  ov: 1'b1, cyc: 65};
        vecs[4] = '{a: 3'd7, b: 3'd1, z: 6'd7,  ov: 1'b1, cyc: 65};
        vecs[5] = '{a: 3'd2, b: 3'd5, z: 6'd10, ov: 1'b1, cyc: 65};
        vecs[6] = '{a: 3'd6, b: 3'd0, z: 6'd0,  ov: ZOV,  cyc: ZCYC};
        vecs[7] = '{a: 3'd3, b: 3'd4, z: 6'd12, ov: 1'b1, cyc: 65};

        bus3.start = 1'b0; bus3.a = '0; bus3.b = '0;
        bus6.start = 1'b0; bus6.a = '0; bus6.b = '0;

        // Reset state
        #1;
        check("reset busy", bus3.busy, 0);
        check("reset done", bus3.done, 0);
        check("reset ov",   bus3.ov,   0);
        check("reset z",    bus3.z,    0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("idle busy after release", bus3.busy, 0);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            do_mul(vecs[i].a, vecs[i].b, ~vecs[i].a, ~vecs[i].b, 1'b0,
                   wc, cyc, bcnt, zv, ovv, early);
            check($sformatf("vec%0d z", i),       zv,    vecs[i].z);
            check($sformatf("vec%0d ov", i),      ovv,   vecs[i].ov);
            check($sformatf("vec%0d latency", i), cyc,   vecs[i].cyc);
            check($sformatf("vec%0d busy cycles", i), bcnt, vecs[i].cyc);
            check($sformatf("vec%0d early ov", i), early, 0);
            @(negedge clk);
            check($sformatf("vec%0d done pulse", i), bus3.done, 0);
            check($sformatf("vec%0d busy after", i), bus3.busy, 0);
            check($sformatf("vec%0d z hold", i),    bus3.z,    vecs[i].z);
        end

        // Start held through RUN with new operands: ignored until IDLE returns
        do_mul(3'd4, 3'd2, 3'd7, 3'd7, 1'b1, wc, cyc, bcnt, zv, ovv, early);
        check("midrun start z", zv, 8);
        check("midrun start latency", cyc, 65);
        do_mul(3'd7, 3'd7, 3'd0, 3'd0, 1'b0, wc, cyc, bcnt, zv, ovv, early);
        check("second request idle gap", wc, 1);
        check("second request z", zv, 49);
        check("second request latency", cyc, 65);

        // Back-to-back with start held
        do_mul(3'd5, 3'd3, 3'd2, 3'd2, 1'b1, wc, cyc, bcnt, zv, ovv, early);
        check("b2b first z", zv, 15);
        check("b2b first ov", ovv, 1);
        do_mul(3'd2, 3'd2, 3'd1, 3'd1, 1'b0, wc, cyc, bcnt, zv, ovv, early);
        check("b2b accept gap", wc, 1);
        check("b2b second z", zv, 4);
        check("b2b second latency", cyc, 65);

        // Reset mid-RUN
        @(negedge clk);
        bus3.start = 1'b1; bus3.a = 3'd6; bus3.b = 3'd6;
        @(negedge clk);
        bus3.start = 1'b0;
        repeat (29) @(negedge clk);
        check("midrun z nonzero before reset", (bus3.z != 0), 1);
        #2 rst = 1'b0;
        #1;
        check("abort z",    bus3.z,    0);
        check("abort busy", bus3.busy, 0);
        check("abort done", bus3.done, 0);
        check("abort ov",   bus3.ov,   0);
        dcnt = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (bus3.done) dcnt++;
        end
        check("abort no done pulse", dcnt, 0);
        rst = 1'b1;
        do_mul(3'd6, 3'd6, 3'd1, 3'd2, 1'b0, wc, cyc, bcnt, zv, ovv, early);
        check("after reset z", zv, 36);
        check("after reset latency", cyc, 65);

        // WIDTH=6 full range
        @(negedge clk);
        bus6.start = 1'b1; bus6.a = 6'd63; bus6.b = 6'd63;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus6.start = 1'b0;
                bus6.a     = 6'd1;
                bus6.b     = 6'd1;
            end
        end while (!bus6.done && cyc < 6000);
        check("w6 latency", cyc, 4097);
        check("w6 z", bus6.z, 3969);
        check("w6 ov", bus6.ov, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
